// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM and access-owner encodings and the grant-selection helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Data wins a tie unless the fetch side has been starved long enough.
    function automatic owner_e pick_owner(input logic if_req, input logic d_req, input logic starved);
        if (if_req && (!d_req || starved)) begin
            return OWN_IF;
        end else begin
            return OWN_D;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the view of the surrounding core and memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned WORD_SIZE    = 32
);
    logic                    IF_REQ;
    logic [ADDRESS_SIZE-1:0] IF_ADDR;
    logic                    IF_VALID;
    logic [WORD_SIZE-1:0]    IF_RDATA;
    logic                    IF_ERR;

    logic                    D_REQ;
    logic                    D_RNW;
    logic [ADDRESS_SIZE-1:0] D_ADDR;
    logic [WORD_SIZE-1:0]    D_WDATA;
    logic                    D_VALID;
    logic [WORD_SIZE-1:0]    D_RDATA;
    logic                    D_ERR;

    logic                    MEM_ENABLE;
    logic                    MEM_READNOTWRITE;
    logic [ADDRESS_SIZE-1:0] MEM_ADDRESS;
    logic [WORD_SIZE-1:0]    MEM_WDATA;
    logic                    MEM_READY;
    logic [WORD_SIZE-1:0]    MEM_RDATA;

    modport slave (
        input  IF_REQ, IF_ADDR, D_REQ, D_RNW, D_ADDR, D_WDATA, MEM_READY, MEM_RDATA,
        output IF_VALID, IF_RDATA, IF_ERR, D_VALID, D_RDATA, D_ERR,
               MEM_ENABLE, MEM_READNOTWRITE, MEM_ADDRESS, MEM_WDATA
    );

    modport master (
        output IF_REQ, IF_ADDR, D_REQ, D_RNW, D_ADDR, D_WDATA, MEM_READY, MEM_RDATA,
        input  IF_VALID, IF_RDATA, IF_ERR, D_VALID, D_RDATA, D_ERR,
               MEM_ENABLE, MEM_READNOTWRITE, MEM_ADDRESS, MEM_WDATA
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Loadable up-counter that stops at LIMIT and flags it; times a single memory access.
module mem_arb_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       load_i,
    input  logic [$clog2(LIMIT+1)-1:0] load_val_i,
    input  logic                       inc_i,
    output logic                       term_o
);
    localparam int unsigned   W    = $clog2(LIMIT + 1);
    localparam logic [W-1:0]  LAST = W'(LIMIT);
    localparam logic [W-1:0]  ONE  = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over increment, and the count parks at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory port,
// with fetch anti-starvation and a per-access timeout.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam int unsigned   TW         = $clog2(TIMEOUT + 1);

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d;
    owner_e                  grant_own;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic                    rnw_q, rnw_d;
    logic                    en_q, en_d;
    logic                    if_valid_q, if_valid_d, d_valid_q, d_valid_d;
    logic                    if_err_q, if_err_d, d_err_q, d_err_d;
    logic [WORD_SIZE-1:0]    if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic                    tmr_load, tmr_inc, tmr_term;

    mem_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (tmr_load),
        .load_val_i (TW'(1)),
        .inc_i      (tmr_inc),
        .term_o     (tmr_term)
    );

    // Next-state, grant and completion logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rnw_d      = rnw_q;
        en_d       = en_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_err_d   = 1'b0;
        d_err_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        starve_d   = starve_q;
        tmr_load   = 1'b0;
        tmr_inc    = 1'b0;
        grant_own  = pick_owner(bus.IF_REQ, bus.D_REQ, starve_q == STARVE_MAX);

        case (state_q)
            IDLE: begin
                if (bus.IF_REQ || bus.D_REQ) begin
                    state_d  = BUSY;
                    owner_d  = grant_own;
                    en_d     = 1'b1;
                    tmr_load = 1'b1;
                    if (grant_own == OWN_D) begin
                        addr_d  = bus.D_ADDR;
                        rnw_d   = bus.D_RNW;
                        wdata_d = bus.D_WDATA;
                        if (bus.IF_REQ && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + SW'(1);
                        end else begin
                            starve_d = starve_q;
                        end
                    end else begin
                        addr_d   = bus.IF_ADDR;
                        rnw_d    = 1'b1;
                        starve_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                tmr_inc = 1'b1;
                // A ready in the timeout cycle still counts as a good completion.
                if (bus.MEM_READY || tmr_term) begin
                    state_d = RESP;
                    en_d    = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_err_d   = !bus.MEM_READY;
                        if (bus.MEM_READY) begin
                            if_rdata_d = bus.MEM_RDATA;
                        end else begin
                            if_rdata_d = '0;
                        end
                    end else begin
                        d_valid_d = 1'b1;
                        d_err_d   = !bus.MEM_READY;
                        if (!bus.MEM_READY) begin
                            d_rdata_d = '0;
                        end else if (rnw_q) begin
                            d_rdata_d = bus.MEM_RDATA;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            rnw_q      <= 1'b1;
            en_q       <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rnw_q      <= rnw_d;
            en_q       <= en_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_err_q   <= if_err_d;
            d_err_q    <= d_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.MEM_ENABLE       = en_q;
    assign bus.MEM_READNOTWRITE = rnw_q;
    assign bus.MEM_ADDRESS      = addr_q;
    assign bus.MEM_WDATA        = wdata_q;
    assign bus.IF_VALID         = if_valid_q;
    assign bus.IF_ERR           = if_err_q;
    assign bus.IF_RDATA         = if_rdata_q;
    assign bus.D_VALID          = d_valid_q;
    assign bus.D_ERR            = d_err_q;
    assign bus.D_RDATA          = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change 1ns after the rising edge
// and outputs are read at the same point.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_rnw;
    logic        cap_en;
    logic        cap_vld_early;
    logic [31:0] exp_drd;
    logic [31:0] exp_ifrd;
    logic        exp_if;
    logic        en_all;
    logic        vld_any;

    mem_arbiter_if #(.ADDRESS_SIZE(32), .WORD_SIZE(32)) bus ();

    mem_arbiter #(
        .ADDRESS_SIZE (32),
        .WORD_SIZE    (32),
        .STARVE_LIMIT (4),
        .TIMEOUT      (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle the request is presented; returns in the response cycle.
    task automatic mem_cycle(input int k, input logic [31:0] rd);
        tick();
        cap_addr      = bus.MEM_ADDRESS;
        cap_rnw       = bus.MEM_READNOTWRITE;
        cap_wdata     = bus.MEM_WDATA;
        cap_en        = 1'b1;
        cap_vld_early = 1'b0;
        for (int i = 1; i <= k; i++) begin
            cap_en        = cap_en & bus.MEM_ENABLE;
            cap_vld_early = cap_vld_early | bus.IF_VALID | bus.D_VALID;
            if (i == k) begin
                bus.MEM_READY = 1'b1;
                bus.MEM_RDATA = rd;
            end
            tick();
        end
        bus.MEM_READY = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.IF_REQ = 1'b0;  bus.IF_ADDR = 32'h0;
        bus.D_REQ  = 1'b0;  bus.D_RNW   = 1'b1;  bus.D_ADDR = 32'h0;  bus.D_WDATA = 32'h0;
        bus.MEM_READY = 1'b0;  bus.MEM_RDATA = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_en",     32'(bus.MEM_ENABLE),       32'd0);
        check("rst_rnw",    32'(bus.MEM_READNOTWRITE), 32'd1);
        check("rst_addr",   bus.MEM_ADDRESS,           32'h0);
        check("rst_wdata",  bus.MEM_WDATA,             32'h0);
        check("rst_vld",    32'({bus.IF_VALID, bus.D_VALID, bus.IF_ERR, bus.D_ERR}), 32'd0);
        check("rst_ifrd",   bus.IF_RDATA,              32'h0);
        check("rst_drd",    bus.D_RDATA,               32'h0);
        rst = 1'b0;

        // Single fetch, memory ready two cycles after enable
        bus.IF_REQ = 1'b1;  bus.IF_ADDR = 32'h10;
        mem_cycle(3, 32'hDEADBEEF);
        check("f_en",       32'(cap_en),               32'd1);
        check("f_addr",     cap_addr,                  32'h10);
        check("f_rnw",      32'(cap_rnw),              32'd1);
        check("f_early",    32'(cap_vld_early),        32'd0);
        check("f_valid",    32'(bus.IF_VALID),         32'd1);
        check("f_rdata",    bus.IF_RDATA,              32'hDEADBEEF);
        check("f_err",      32'(bus.IF_ERR),           32'd0);
        check("f_resp_en",  32'(bus.MEM_ENABLE),       32'd0);
        bus.IF_REQ = 1'b0;
        tick();
        check("f_pulse",    32'(bus.IF_VALID),         32'd0);
        check("f_hold",     bus.IF_RDATA,              32'hDEADBEEF);

        // Memory ready while idle is ignored
        bus.MEM_READY = 1'b1;  bus.MEM_RDATA = 32'h11111111;
        tick();
        bus.MEM_READY = 1'b0;
        check("idle_rdy_vld", 32'({bus.IF_VALID, bus.D_VALID}), 32'd0);
        check("idle_rdy_en",  32'(bus.MEM_ENABLE),     32'd0);
        check("idle_rdy_rd",  bus.IF_RDATA,            32'hDEADBEEF);

        // Simultaneous requests: data store goes first
        bus.IF_REQ = 1'b1;  bus.IF_ADDR = 32'h20;
        bus.D_REQ  = 1'b1;  bus.D_RNW   = 1'b0;  bus.D_ADDR = 32'h40;  bus.D_WDATA = 32'h55;
        mem_cycle(1, 32'h11112222);
        check("tie_addr",   cap_addr,                  32'h40);
        check("tie_rnw",    32'(cap_rnw),              32'd0);
        check("tie_wdata",  cap_wdata,                 32'h55);
        check("tie_dvld",   32'(bus.D_VALID),          32'd1);
        check("tie_ifvld",  32'(bus.IF_VALID),         32'd0);
        check("st_rdata",   bus.D_RDATA,               32'h0);
        bus.D_REQ = 1'b0;
        tick();
        mem_cycle(2, 32'hCAFE0001);
        check("tie2_addr",  cap_addr,                  32'h20);
        check("tie2_rnw",   32'(cap_rnw),              32'd1);
        check("tie2_ifvld", 32'(bus.IF_VALID),         32'd1);
        check("tie2_dvld",  32'(bus.D_VALID),          32'd0);
        check("tie2_rd",    bus.IF_RDATA,              32'hCAFE0001);
        bus.IF_REQ = 1'b0;
        tick();

        // Starvation: four data grants, then fetch, then data again
        exp_drd  = 32'h0;
        exp_ifrd = 32'hCAFE0001;
        bus.IF_REQ = 1'b1;  bus.IF_ADDR = 32'h30;
        bus.D_REQ  = 1'b1;  bus.D_RNW   = 1'b1;  bus.D_ADDR = 32'h80;
        for (int g = 1; g <= 6; g++) begin
            mem_cycle(1, 32'h100 + 32'(g));
            exp_if = (g == 5);
            if (exp_if) begin
                exp_ifrd = 32'h100 + 32'(g);
            end else begin
                exp_drd = 32'h100 + 32'(g);
            end
            check("stv_addr",  cap_addr,               exp_if ? 32'h30 : 32'h80);
            check("stv_ifvld", 32'(bus.IF_VALID),      32'(exp_if));
            check("stv_dvld",  32'(bus.D_VALID),       32'(!exp_if));
            check("stv_drd",   bus.D_RDATA,            exp_drd);
            check("stv_ifrd",  bus.IF_RDATA,           exp_ifrd);
            if (g == 6) begin
                bus.IF_REQ = 1'b0;
                bus.D_REQ  = 1'b0;
            end
            tick();
        end

        // Timeout: memory never ready
        bus.D_REQ = 1'b1;  bus.D_RNW = 1'b1;  bus.D_ADDR = 32'h90;
        bus.MEM_RDATA = 32'h77777777;
        en_all  = 1'b1;
        vld_any = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            en_all  = en_all & bus.MEM_ENABLE;
            vld_any = vld_any | bus.D_VALID | bus.IF_VALID;
        end
        check("to_en",      32'(en_all),               32'd1);
        check("to_early",   32'(vld_any),              32'd0);
        tick();
        check("to_valid",   32'(bus.D_VALID),          32'd1);
        check("to_err",     32'(bus.D_ERR),            32'd1);
        check("to_rdata",   bus.D_RDATA,               32'h0);
        check("to_resp_en", 32'(bus.MEM_ENABLE),       32'd0);
        bus.D_REQ = 1'b0;
        tick();
        check("to_pulse",   32'({bus.D_VALID, bus.D_ERR}), 32'd0);

        // Ready on the last allowed BUSY cycle
        bus.IF_REQ = 1'b1;  bus.IF_ADDR = 32'h44;
        mem_cycle(16, 32'h12345678);
        check("edge_early", 32'(cap_vld_early),        32'd0);
        check("edge_valid", 32'(bus.IF_VALID),         32'd1);
        check("edge_err",   32'(bus.IF_ERR),           32'd0);
        check("edge_rdata", bus.IF_RDATA,              32'h12345678);
        bus.IF_REQ = 1'b0;
        tick();

        // Reset during the second BUSY cycle
        bus.D_REQ = 1'b1;  bus.D_RNW = 1'b0;  bus.D_ADDR = 32'h60;  bus.D_WDATA = 32'h99;
        tick();
        tick();
        check("ra_busy_en", 32'(bus.MEM_ENABLE),       32'd1);
        rst = 1'b1;
        bus.D_REQ = 1'b0;
        tick();
        rst = 1'b0;
        check("ra_en",      32'(bus.MEM_ENABLE),       32'd0);
        check("ra_vld",     32'({bus.IF_VALID, bus.D_VALID}), 32'd0);
        check("ra_addr",    bus.MEM_ADDRESS,           32'h0);
        check("ra_rnw",     32'(bus.MEM_READNOTWRITE), 32'd1);
        check("ra_ifrd",    bus.IF_RDATA,              32'h0);
        tick();
        check("ra_vld2",    32'({bus.IF_VALID, bus.D_VALID}), 32'd0);
        bus.IF_REQ = 1'b1;  bus.IF_ADDR = 32'h70;
        mem_cycle(2, 32'hA5A5A5A5);
        check("ra_new_addr", cap_addr,                 32'h70);
        check("ra_new_vld", 32'(bus.IF_VALID),         32'd1);
        check("ra_new_rd",  bus.IF_RDATA,              32'hA5A5A5A5);
        bus.IF_REQ = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_SIZE, default 32, width of all address ports.
REQ-002 Parameter WORD_SIZE, default 32, width of all data ports.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while fetch waits.
REQ-004 Parameter TIMEOUT, default 16, max BUSY cycles before abort.
REQ-005 CLK  in  1  single clock, all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 IF_REQ  in  1  fetch request, held until IF_VALID.
REQ-008 IF_ADDR  in  ADDRESS_SIZE  fetch address, stable while IF_REQ.
REQ-009 IF_VALID  out  1  one-cycle fetch completion pulse.
REQ-010 IF_RDATA  out  WORD_SIZE  fetched word, valid with IF_VALID.
REQ-011 IF_ERR  out  1  fetch timed out, qualifies IF_VALID.
REQ-012 D_REQ  in  1  data request, held until D_VALID.
REQ-013 D_RNW  in  1  1 = load, 0 = store.
REQ-014 D_ADDR  in  ADDRESS_SIZE  data address.
REQ-015 D_WDATA  in  WORD_SIZE  store data.
REQ-016 D_VALID / D_RDATA / D_ERR  out  1 / WORD_SIZE / 1  as IF_* for data port.
REQ-017 MEM_ENABLE  out  1  memory access strobe.
REQ-018 MEM_READNOTWRITE  out  1  memory direction.
REQ-019 MEM_ADDRESS  out  ADDRESS_SIZE  memory address.
REQ-020 MEM_WDATA  out  WORD_SIZE  memory write data.
REQ-021 MEM_READY  in  1  memory completion (DATA_READY).
REQ-022 MEM_RDATA  in  WORD_SIZE  memory read data, valid with MEM_READY.

Function
REQ-023 FSM states IDLE, BUSY, RESP; one access outstanding at a time.
REQ-024 IDLE: if any request sampled, latch winner's address/rnw/wdata and owner, go BUSY; else stay.
REQ-025 Arbitration: D wins ties, except IF wins when starve counter equals STARVE_LIMIT.
REQ-026 Starve counter: +1 per D grant while IF_REQ high; cleared on IF grant; saturates at STARVE_LIMIT.
REQ-027 BUSY: MEM_ENABLE=1, MEM_ADDRESS/MEM_READNOTWRITE/MEM_WDATA from latches (IF forces READNOTWRITE=1); held constant.
REQ-028 BUSY with MEM_READY=1: capture MEM_RDATA (loads/fetches) into owner's RDATA, go RESP.
REQ-029 BUSY timer counts from 1; reaching TIMEOUT without MEM_READY: owner RDATA=0, owner ERR=1, go RESP.
REQ-030 MEM_READY and timeout in same cycle: MEM_READY wins, ERR=0.
REQ-031 RESP: owner VALID=1 one cycle, MEM_ENABLE=0, go IDLE; requests ignored in RESP.
REQ-032 Latency: REQ sampled cycle 0, MEM_ENABLE cycles 1..k (k=READY cycle), VALID cycle k+1; back-to-back grant earliest cycle k+2.
REQ-033 Store completion: D_VALID pulses, D_RDATA unchanged.
REQ-034 RDATA registers hold last value until next completion for that port.
REQ-035 MEM_READY outside BUSY ignored.

Reset
REQ-036 RST sampled high: state IDLE, MEM_ENABLE=0, MEM_READNOTWRITE=1, MEM_ADDRESS=0, MEM_WDATA=0, all VALID/ERR=0, RDATA=0, counters 0.
REQ-037 RST mid-BUSY aborts silently: no VALID pulse, MEM_ENABLE low after the reset edge.

Structure
REQ-038 Package mem_arb_pkg holds state enum (IDLE/BUSY/RESP) and owner enum (OWN_IF/OWN_D).
REQ-039 Sub-module mem_arb_timer: loadable up-counter with terminal flag, used for BUSY timeout.

Verification
REQ-040 Fetch only, IF_ADDR=0x10, memory READY 2 cycles after ENABLE, RDATA=0xDEADBEEF -> IF_VALID at cycle 4, IF_RDATA=0xDEADBEEF, IF_ERR=0.
REQ-041 IF_REQ and D_REQ same cycle, D store 0x55 to 0x40 -> store issued first (READNOTWRITE=0, WDATA=0x55), then fetch; D_VALID precedes IF_VALID.
REQ-042 D_REQ held continuously with IF_REQ high -> after 4 data grants the 5th grant goes to IF, counter clears.
REQ-043 MEM_READY never asserted, TIMEOUT=16 -> owner VALID and ERR high together 17 cycles after grant, RDATA=0.
REQ-044 MEM_READY on exactly the 16th BUSY cycle -> normal completion, ERR=0.
REQ-045 RST asserted in 2nd BUSY cycle -> MEM_ENABLE=0 next cycle, no VALID, new request afterwards served normally.
